// File: rtl/prbs_ber_checker_pkg.sv
// prbs_ber_checker_pkg: PRBS7 (x^7+x^6+1) constants and checker state encodings
package prbs_ber_checker_pkg;
   localparam int PRBS_LEN = 7;
   localparam int TAP_A = 6;
   localparam int TAP_B = 5;
   localparam logic [0:0] ST_SEARCH = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
endpackage

// File: rtl/prbs7_lfsr.sv
// prbs7_lfsr: PRBS7 shift register that either self-loads received bits or free-runs on its own prediction
module prbs7_lfsr
   import prbs_ber_checker_pkg::*;
(
   input  logic                clk_fast,
   input  logic                rst,
   input  logic                adv,
   input  logic                load_sel,
   input  logic                din,
   output logic [PRBS_LEN-1:0] state,
   output logic                pred
);
   assign pred = state[TAP_A] ^ state[TAP_B];
   always_ff @(posedge clk_fast or negedge rst)
      if (!rst) state <= '0;
      else if (adv) state <= {state[PRBS_LEN-2:0], load_sel ? din : pred};
endmodule

// File: rtl/prbs_ber_checker.sv
// prbs_ber_checker: self-synchronising PRBS7 bit-error-rate checker with lock/loss tracking
module prbs_ber_checker
   import prbs_ber_checker_pkg::*;
#(
   parameter int LOCK_BITS   = 16,
   parameter int WINDOW      = 64,
   parameter int UNLOCK_ERRS = 8,
   parameter int CNT_W       = 24
) (
   input  logic             clk_fast,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             clr,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] bit_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [7:0]       loss_cnt
);
   localparam int MW = $clog2(LOCK_BITS + 1);
   localparam int WW = $clog2(WINDOW);
   localparam int EW = $clog2(WINDOW + 1);
   logic [0:0] st;
   logic [2:0] fill;
   logic [MW-1:0] match;
   logic [WW-1:0] win_bits;
   logic [EW-1:0] win_errs, errs_now;
   logic [PRBS_LEN-1:0] unused_lfsr;
   logic pred, err, win_end, drop;
   prbs7_lfsr u_lfsr (
      .clk_fast(clk_fast),
      .rst(rst),
      .adv(bit_valid),
      .load_sel(st == ST_SEARCH),
      .din(bit_in),
      .state(unused_lfsr),
      .pred(pred)
   );
   assign locked   = st == ST_LOCKED;
   assign err      = pred != bit_in;
   assign win_end  = win_bits == WW'(WINDOW - 1);
   // the window's last bit takes part in its own loss-of-lock decision
   assign errs_now = win_errs + EW'(err);
   assign drop     = win_end && errs_now >= EW'(UNLOCK_ERRS);
   always_ff @(posedge clk_fast or negedge rst)
      if (!rst) begin
         st        <= ST_SEARCH;
         fill      <= '0;
         match     <= '0;
         win_bits  <= '0;
         win_errs  <= '0;
         err_pulse <= 1'b0;
         bit_cnt   <= '0;
         err_cnt   <= '0;
         loss_cnt  <= '0;
      end else begin
         err_pulse <= bit_valid && locked && err;
         if (bit_valid && !locked) begin
            if (fill != 3'd7) fill <= fill + 3'd1;
            else if (err) match <= '0;
            else if (match == MW'(LOCK_BITS - 1)) begin
               st       <= ST_LOCKED;
               match    <= '0;
               win_bits <= '0;
               win_errs <= '0;
            end else match <= match + MW'(1);
         end
         if (bit_valid && locked) begin
            bit_cnt <= bit_cnt + CNT_W'(~&bit_cnt);
            err_cnt <= err_cnt + CNT_W'(err && ~&err_cnt);
            win_bits <= win_end ? '0 : win_bits + WW'(1);
            win_errs <= win_end ? '0 : errs_now;
            if (drop) begin
               st       <= ST_SEARCH;
               fill     <= '0;
               match    <= '0;
               loss_cnt <= loss_cnt + 8'(~&loss_cnt);
            end
         end
         if (clr) begin
            bit_cnt  <= '0;
            err_cnt  <= '0;
            loss_cnt <= '0;
            win_bits <= '0;
            win_errs <= '0;
         end
      end
endmodule
